uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 17 +
 rtl/uart_tx_arbiter.sv | 94 +++++++++
 tb/tb_uart_tx_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and constants for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_BUSY, SENDING} state_t;
  localparam int UART_BYTE_W = 8;
  localparam int DEF_BUSY_TIMEOUT = 2048;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: masked one-hot round-robin picker; search starts at i_Ptr and wraps
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_Req,
  input  logic [N-1:0]  i_Mask,
  input  logic [PW-1:0] i_Ptr,
  output logic [N-1:0]  o_Grant
);
  logic [N-1:0] w_req, w_hi, w_sel;
  assign w_req   = i_Req & i_Mask;
  // requests at or above the pointer win; otherwise wrap to the lowest request
  assign w_hi    = w_req & ~((N'(1) << i_Ptr) - N'(1));
  assign w_sel   = (|w_hi) ? w_hi : w_req;
  assign o_Grant = w_sel & (~w_sel + N'(1));
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between requesters with message locking
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                           i_Clock,
  input  logic                           i_Reset,
  input  logic [NUM_REQ-1:0]             i_Req_Valid,
  input  logic [NUM_REQ*UART_BYTE_W-1:0] i_Req_Data,
  input  logic [NUM_REQ-1:0]             i_Req_Last,
  output logic [NUM_REQ-1:0]             o_Req_Ready,
  output logic                           o_Start,
  output logic [UART_BYTE_W-1:0]         o_Data,
  input  logic                           i_Busy,
  output logic [NUM_REQ-1:0]             o_Grant,
  output logic                           o_Error
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  state_t                 r_state;
  logic [PW-1:0]          r_ptr, r_owner, w_idx;
  logic                   r_lock, w_last, w_accept;
  logic [TW-1:0]          r_cnt, w_cnt_nx;
  logic [NUM_REQ-1:0]     w_pick, w_mask;
  logic [UART_BYTE_W-1:0] w_byte;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(NUM_REQ - 1)) ? '0 : p + PW'(1);
  endfunction
  // a held lock narrows arbitration to the owner alone
  assign w_mask = r_lock ? NUM_REQ'(1) << r_owner : '1;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_rr (
    .i_Req  (i_Req_Valid),
    .i_Mask (w_mask),
    .i_Ptr  (r_ptr),
    .o_Grant(w_pick)
  );
  assign o_Req_Ready = (r_state == IDLE && !i_Busy && !i_Reset) ? w_pick : '0;
  assign w_accept    = |o_Req_Ready;
  assign o_Grant     = (r_state != IDLE || r_lock) ? NUM_REQ'(1) << r_owner : '0;
  assign w_cnt_nx    = r_cnt + TW'(1);
  always_comb begin
    w_idx  = '0;
    w_byte = '0;
    w_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick[i]) begin
        w_idx  = PW'(i);
        w_byte = i_Req_Data[i*UART_BYTE_W +: UART_BYTE_W];
        w_last = i_Req_Last[i];
      end
    end
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state <= IDLE;
      o_Start <= 1'b0;
      o_Data  <= '0;
      o_Error <= 1'b0;
      r_lock  <= 1'b0;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_state <= WAIT_BUSY;
          o_Start <= 1'b1;
          o_Data  <= w_byte;
          r_owner <= w_idx;
          r_cnt   <= '0;
          r_lock  <= !w_last;
          if (w_last) r_ptr <= nxt(w_idx);
        end
        WAIT_BUSY: if (i_Busy) begin
          r_state <= SENDING;
          o_Start <= 1'b0;
        end else if (w_cnt_nx == TW'(BUSY_TIMEOUT)) begin
          // the UART never acknowledged: abandon the byte and release the owner
          r_state <= IDLE;
          o_Start <= 1'b0;
          o_Error <= 1'b1;
          r_lock  <= 1'b0;
          r_ptr   <= nxt(r_owner);
        end else begin
          r_cnt <= w_cnt_nx;
        end
        SENDING: if (!i_Busy) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural UART busy model
module tb_uart_tx_arbiter;
  localparam int NR = 3;
  localparam int BT = 20;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] vld = '0, lst = '0;
  logic [NR*8-1:0] dat = '0;
  logic busy_m = 1'b0, busy_f = 1'b0, mute = 1'b0;
  int busy_len = 3;
  logic [NR-1:0] rdy, gnt;
  logic start, err;
  logic [7:0] data;
  int checks = 0, errors = 0;
  logic [8:0] fd [NR][8];
  int fn [NR];
  int fi [NR];
  logic [10:0] exq [$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(BT)) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_Req_Valid(vld),
    .i_Req_Data (dat),
    .i_Req_Last (lst),
    .o_Req_Ready(rdy),
    .o_Start    (start),
    .o_Data     (data),
    .i_Busy     (busy_m | busy_f),
    .o_Grant    (gnt),
    .o_Error    (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int r = 0; r < NR; r++) begin
      vld[r] = fi[r] < fn[r];
      dat[r*8 +: 8] = vld[r] ? fd[r][fi[r]][7:0] : 8'h00;
      lst[r] = vld[r] ? fd[r][fi[r]][8] : 1'b0;
    end
  endtask

  task automatic feed(input int r, input logic [7:0] d, input logic l);
    fd[r][fn[r]] = {l, d};
    fn[r]++;
  endtask

  task automatic exp_b(input int r, input logic [7:0] d);
    exq.push_back({(NR'(1) << r), d});
  endtask

  task automatic clear_feeds();
    for (int r = 0; r < NR; r++) begin
      fn[r] = 0;
      fi[r] = 0;
    end
  endtask

  task automatic go();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    go();
    rst = 1'b1;
    mute = 1'b0;
    busy_f = 1'b0;
    clear_feeds();
    drive();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 500 && !(exq.size() == 0 && !start && gnt == '0 && !busy_m && vld == '0)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d bytes still expected, start=%b grant=%b", exq.size(), start, gnt);
    end
    @(negedge clk);
  endtask

  // requester side: consume the head byte on each valid&ready handshake
  initial begin
    logic [NR-1:0] acc;
    forever begin
      @(negedge clk);
      acc = vld & rdy;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) if (acc[r]) fi[r]++;
      drive();
    end
  end

  // UART model: busy rises in the fourth cycle after start is first seen
  initial begin
    forever begin
      @(negedge clk);
      if (start && !mute) begin
        repeat (4) @(posedge clk);
        #1 busy_m = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 busy_m = 1'b0;
      end
    end
  end

  initial begin
    logic ps;
    logic [10:0] e;
    ps = 1'b0;
    forever begin
      @(negedge clk);
      if (start && !ps) begin
        if (exq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got grant %b data %h, expected none", gnt, data);
        end else begin
          e = exq.pop_front();
          chk("sb_grant", 32'(gnt), 32'(e[10:8]));
          chk("sb_data", 32'(data), 32'(e[7:0]));
        end
      end
      ps = start;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_feeds();
    drive();
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(start), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_ready", 32'(rdy), 0);
    chk("rst_grant", 32'(gnt), 0);
    chk("rst_error", 32'(err), 0);
    go();
    rst = 1'b0;
    // single byte with cycle-exact start/busy timing
    go();
    feed(0, 8'hA5, 1'b1);
    exp_b(0, 8'hA5);
    drive();
    n = 0;
    @(negedge clk);
    while (!rdy[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready0_n", 32'(rdy), 32'h1);
    @(negedge clk);
    chk("start_n1", 32'(start), 1);
    repeat (4) @(negedge clk);
    chk("start_n5", 32'(start), 1);
    @(negedge clk);
    chk("start_n6", 32'(start), 0);
    drain();
    // three requesters, two single-byte messages each
    do_reset();
    feed(0, 8'h10, 1'b1); feed(0, 8'h13, 1'b1);
    feed(1, 8'h11, 1'b1); feed(1, 8'h14, 1'b1);
    feed(2, 8'h12, 1'b1); feed(2, 8'h15, 1'b1);
    exp_b(0, 8'h10); exp_b(1, 8'h11); exp_b(2, 8'h12);
    exp_b(0, 8'h13); exp_b(1, 8'h14); exp_b(2, 8'h15);
    drive();
    drain();
    // locked three-byte message from requester 1
    do_reset();
    feed(0, 8'hA0, 1'b1);
    exp_b(0, 8'hA0);
    drive();
    drain();
    go();
    feed(0, 8'hB0, 1'b1);
    feed(1, 8'h11, 1'b0); feed(1, 8'h22, 1'b0); feed(1, 8'h33, 1'b1);
    feed(2, 8'hC2, 1'b1);
    exp_b(1, 8'h11); exp_b(1, 8'h22); exp_b(1, 8'h33);
    exp_b(2, 8'hC2); exp_b(0, 8'hB0);
    drive();
    drain();
    chk("no_error", 32'(err), 0);
    // busy never rises: timeout path
    do_reset();
    mute = 1'b1;
    feed(0, 8'h5A, 1'b1);
    feed(1, 8'h6B, 1'b1);
    exp_b(0, 8'h5A);
    exp_b(1, 8'h6B);
    drive();
    n = 0;
    while (!start && n < 50) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (start && n < 100) begin
      n++;
      @(negedge clk);
    end
    mute = 1'b0;
    chk("timeout_cycles", 32'(n), BT);
    chk("error_set", 32'(err), 1);
    drain();
    chk("error_sticky", 32'(err), 1);
    // reset in the middle of a locked message
    do_reset();
    feed(2, 8'h77, 1'b0);
    feed(2, 8'h88, 1'b1);
    exp_b(2, 8'h77);
    drive();
    n = 0;
    while (!busy_m && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("locked_grant", 32'(gnt), 32'h4);
    go();
    rst = 1'b1;
    clear_feeds();
    feed(0, 8'h99, 1'b1);
    feed(2, 8'h88, 1'b1);
    exp_b(0, 8'h99);
    exp_b(2, 8'h88);
    drive();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_start", 32'(start), 0);
    chk("midrst_grant", 32'(gnt), 0);
    chk("midrst_ready", 32'(rdy), 0);
    go();
    rst = 1'b0;
    drain();
    // external busy in IDLE blocks every accept
    go();
    busy_f = 1'b1;
    feed(1, 8'h42, 1'b1);
    exp_b(1, 8'h42);
    drive();
    repeat (6) begin
      @(negedge clk);
      chk("busy_block", 32'(rdy), 0);
    end
    go();
    busy_f = 1'b0;
    @(negedge clk);
    chk("busy_release", 32'(rdy), 32'h2);
    drain();
    chk("scoreboard_empty", 32'(exq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
